// File: rtl/core_desc_io_if.sv
// Core IO register bus plus the in/out descriptor streams of core_desc_io.
// Widths must match the DESC_WIDTH/ADDR_WIDTH given to core_desc_io.
interface core_desc_io_if #(
    parameter int DESC_WIDTH = 64,
    parameter int ADDR_WIDTH = 16
);
    logic                  io_v;
    logic                  io_wr;
    logic [ADDR_WIDTH-1:0] io_addr;
    logic [31:0]           io_wdata;
    logic [3:0]            io_wstrb;
    logic [31:0]           io_rdata;
    logic                  io_rvalid;
    logic                  io_err;
    logic [DESC_WIDTH-1:0] in_desc;
    logic                  in_desc_valid;
    logic                  in_desc_ready;
    logic [DESC_WIDTH-1:0] out_desc;
    logic                  out_desc_valid;
    logic                  out_desc_ready;

    modport master (
        output io_v, io_wr, io_addr, io_wdata, io_wstrb,
        output in_desc, in_desc_valid, out_desc_ready,
        input  io_rdata, io_rvalid, io_err,
        input  in_desc_ready, out_desc, out_desc_valid
    );

    modport slave (
        input  io_v, io_wr, io_addr, io_wdata, io_wstrb,
        input  in_desc, in_desc_valid, out_desc_ready,
        output io_rdata, io_rvalid, io_err,
        output in_desc_ready, out_desc, out_desc_valid
    );
endinterface

// File: rtl/core_desc_io.sv
// Descriptor mailbox: host descriptors queue for the core to read/pop over a
// 32-bit register port; the core assembles descriptors in a staging register and pushes them out.
module core_desc_io #(
    parameter int DESC_WIDTH = 64,
    parameter int IN_DEPTH   = 4,
    parameter int OUT_DEPTH  = 4,
    parameter int ADDR_WIDTH = 16
) (
    input logic          clk,
    input logic          core_reset,
    core_desc_io_if.slave bus
);
    localparam int W   = DESC_WIDTH / 32;
    localparam int IPW = $clog2(IN_DEPTH);
    localparam int OPW = $clog2(OUT_DEPTH);
    localparam int ICW = IPW + 1;
    localparam int OCW = OPW + 1;
    localparam logic [3:0]     W4       = 4'(W);
    localparam logic [ICW-1:0] IN_FULL  = ICW'(IN_DEPTH);
    localparam logic [OCW-1:0] OUT_FULL = OCW'(OUT_DEPTH);

    logic [DESC_WIDTH-1:0] in_mem_q  [IN_DEPTH];
    logic [DESC_WIDTH-1:0] in_mem_d  [IN_DEPTH];
    logic [DESC_WIDTH-1:0] out_mem_q [OUT_DEPTH];
    logic [DESC_WIDTH-1:0] out_mem_d [OUT_DEPTH];
    logic [IPW-1:0] in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
    logic [OPW-1:0] out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;
    logic [ICW-1:0] in_count_q, in_count_d;
    logic [OCW-1:0] out_count_q, out_count_d;
    logic [DESC_WIDTH-1:0] stage_q, stage_d;
    logic [31:0] io_rdata_q, io_rdata_d;
    logic io_rvalid_q, io_rvalid_d;
    logic io_err_q, io_err_d;
    logic out_ovf_q, out_ovf_d;
    logic rd_empty_q, rd_empty_d;

    logic [3:0] k;
    logic wr_req, rd_req, is_desc, is_status, is_ctrl, is_hole, is_bad;
    logic ctrl_pop, ctrl_push, in_enq, in_deq, out_enq, out_deq;
    logic [DESC_WIDTH-1:0] in_head;
    logic [31:0] rd_word, status;

    assign k         = bus.io_addr[5:2];
    assign wr_req    = bus.io_v & bus.io_wr;
    assign rd_req    = bus.io_v & ~bus.io_wr;
    assign is_desc   = k < W4;
    assign is_status = k == 4'd8;
    assign is_ctrl   = k == 4'd9;
    assign is_hole   = ~is_desc & (k < 4'd8);
    assign is_bad    = k > 4'd9;

    assign ctrl_pop  = wr_req & is_ctrl & bus.io_wstrb[0] & bus.io_wdata[0];
    assign ctrl_push = wr_req & is_ctrl & bus.io_wstrb[0] & bus.io_wdata[1];
    assign in_enq    = bus.in_desc_valid & bus.in_desc_ready;
    assign in_deq    = ctrl_pop & (in_count_q != '0);
    // A full output FIFO drops the push even if it drains this same cycle.
    assign out_enq   = ctrl_push & (out_count_q != OUT_FULL);
    assign out_deq   = bus.out_desc_valid & bus.out_desc_ready;

    assign in_head = in_mem_q[in_rd_ptr_q];
    assign status  = {13'b0, rd_empty_q, out_ovf_q, 1'b0, 8'(out_count_q), 8'(in_count_q)};

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < W; i++)
            if (k == 4'(i)) rd_word = in_head[32*i +: 32];
    end

    always_comb begin
        stage_d = stage_q;
        for (int i = 0; i < W; i++)
            for (int b = 0; b < 4; b++)
                if (wr_req && k == 4'(i) && bus.io_wstrb[b])
                    stage_d[32*i + 8*b +: 8] = bus.io_wdata[8*b +: 8];
    end

    always_comb begin
        in_mem_d     = in_mem_q;
        in_wr_ptr_d  = in_wr_ptr_q;
        in_rd_ptr_d  = in_rd_ptr_q;
        out_mem_d    = out_mem_q;
        out_wr_ptr_d = out_wr_ptr_q;
        out_rd_ptr_d = out_rd_ptr_q;
        if (in_enq) begin
            in_mem_d[in_wr_ptr_q] = bus.in_desc;
            in_wr_ptr_d = in_wr_ptr_q + IPW'(1);
        end
        if (in_deq) in_rd_ptr_d = in_rd_ptr_q + IPW'(1);
        // Push takes stage_d so byte writes landing this cycle are included.
        if (out_enq) begin
            out_mem_d[out_wr_ptr_q] = stage_d;
            out_wr_ptr_d = out_wr_ptr_q + OPW'(1);
        end
        if (out_deq) out_rd_ptr_d = out_rd_ptr_q + OPW'(1);
        in_count_d  = in_count_q + ICW'(in_enq) - ICW'(in_deq);
        out_count_d = out_count_q + OCW'(out_enq) - OCW'(out_deq);
    end

    always_comb begin
        io_rvalid_d = rd_req;
        io_rdata_d  = '0;
        rd_empty_d  = rd_empty_q | (ctrl_pop & (in_count_q == '0));
        out_ovf_d   = out_ovf_q | (ctrl_push & (out_count_q == OUT_FULL));
        io_err_d    = io_err_q
                    | (wr_req & (is_status | is_hole | is_bad))
                    | (rd_req & (is_ctrl | is_hole | is_bad));
        if (rd_req) begin
            if (is_desc) begin
                if (in_count_q != '0) io_rdata_d = rd_word;
                else                  rd_empty_d = 1'b1;
            end else if (is_status) begin
                io_rdata_d = status;
            end
        end
    end

    always_ff @(posedge clk or posedge core_reset) begin
        if (core_reset) begin
            in_wr_ptr_q  <= '0;
            in_rd_ptr_q  <= '0;
            in_count_q   <= '0;
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            out_count_q  <= '0;
            stage_q      <= '0;
            io_rdata_q   <= '0;
            io_rvalid_q  <= 1'b0;
            io_err_q     <= 1'b0;
            out_ovf_q    <= 1'b0;
            rd_empty_q   <= 1'b0;
        end else begin
            in_wr_ptr_q  <= in_wr_ptr_d;
            in_rd_ptr_q  <= in_rd_ptr_d;
            in_count_q   <= in_count_d;
            out_wr_ptr_q <= out_wr_ptr_d;
            out_rd_ptr_q <= out_rd_ptr_d;
            out_count_q  <= out_count_d;
            stage_q      <= stage_d;
            io_rdata_q   <= io_rdata_d;
            io_rvalid_q  <= io_rvalid_d;
            io_err_q     <= io_err_d;
            out_ovf_q    <= out_ovf_d;
            rd_empty_q   <= rd_empty_d;
        end
    end

    // Storage only; validity is tracked by the reset pointers and counts.
    always_ff @(posedge clk) begin
        in_mem_q  <= in_mem_d;
        out_mem_q <= out_mem_d;
    end

    assign bus.io_rdata       = io_rdata_q;
    assign bus.io_rvalid      = io_rvalid_q;
    assign bus.io_err         = io_err_q;
    assign bus.in_desc_ready  = in_count_q != IN_FULL;
    assign bus.out_desc       = out_mem_q[out_rd_ptr_q];
    assign bus.out_desc_valid = out_count_q != '0;
endmodule

// File: tb/tb_core_desc_io.sv
module tb_core_desc_io;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [31:0] rd;
  logic        rv;
  logic        done = 1'b0;

  always #5 clk = ~clk;

  core_desc_io_if #(.DESC_WIDTH(64), .ADDR_WIDTH(16)) bus ();

  core_desc_io #(.DESC_WIDTH(64), .IN_DEPTH(4), .OUT_DEPTH(4), .ADDR_WIDTH(16)) dut (
    .clk(clk), .core_reset(rst), .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [3:0] k, input logic [31:0] d, input logic [3:0] s);
    bus.io_v = 1'b1; bus.io_wr = 1'b1; bus.io_addr = 16'(k) << 2;
    bus.io_wdata = d; bus.io_wstrb = s;
    step();
    bus.io_v = 1'b0; bus.io_wr = 1'b0;
  endtask

  task automatic io_read(input logic [3:0] k, output logic [31:0] d, output logic v);
    bus.io_v = 1'b1; bus.io_wr = 1'b0; bus.io_addr = 16'(k) << 2;
    step();
    d = bus.io_rdata; v = bus.io_rvalid;
    bus.io_v = 1'b0;
  endtask

  initial begin
    #200000;
    if (!done) begin
      fails++;
      $error("FAIL timeout: bench did not finish within the wait limit");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    bus.io_v = 0; bus.io_wr = 0; bus.io_addr = '0; bus.io_wdata = '0; bus.io_wstrb = '0;
    bus.in_desc = '0; bus.in_desc_valid = 0; bus.out_desc_ready = 0;
    #2;
    tests += 5;
    if (bus.in_desc_ready !== 1'b1 || bus.out_desc_valid !== 1'b0 || bus.io_err !== 1'b0 ||
        bus.io_rvalid !== 1'b0 || bus.io_rdata !== 32'h0) begin
      fails++;
      $error("FAIL reset state: in_ready=%b out_valid=%b err=%b rvalid=%b rdata=%0h",
             bus.in_desc_ready, bus.out_desc_valid, bus.io_err, bus.io_rvalid, bus.io_rdata);
    end
    step(); step();
    rst = 1'b0;
    step();

    bus.in_desc = 64'h11223344_55667788; bus.in_desc_valid = 1'b1;
    step();
    bus.in_desc_valid = 1'b0;
    io_read(4'd0, rd, rv);
    chk("rd_k0_valid", rv, 1'b1);
    chk("rd_k0_data", rd, 32'h55667788);
    step();
    chk("rvalid_drop", bus.io_rvalid, 1'b0);
    io_read(4'd1, rd, rv);
    chk("rd_k1_data", rd, 32'h11223344);
    io_write(4'd9, 32'h1, 4'hF);
    io_read(4'd8, rd, rv);
    chk("status_after_pop", rd, 32'h0);

    io_write(4'd0, 32'hAABBCCDD, 4'hF);
    io_write(4'd1, 32'h01020304, 4'b0011);
    io_write(4'd9, 32'h2, 4'hF);
    chk("push_desc", bus.out_desc, 64'h00000304_AABBCCDD);
    chk("push_valid", bus.out_desc_valid, 1'b1);
    io_read(4'd8, rd, rv);
    chk("status_out1", rd, 32'h00000100);
    bus.out_desc_ready = 1'b1;
    step();
    bus.out_desc_ready = 1'b0;
    chk("drain_one", bus.out_desc_valid, 1'b0);

    for (int i = 0; i < 5; i++) begin
      io_write(4'd0, 32'hD0000000 + i, 4'hF);
      io_write(4'd9, 32'h2, 4'hF);
    end
    io_read(4'd8, rd, rv);
    chk("status_ovf", rd, 32'h00020400);
    bus.out_desc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", bus.out_desc_valid, 1'b1);
      chk("drain_order", bus.out_desc, {32'h00000304, 32'hD0000000 + i});
      step();
    end
    bus.out_desc_ready = 1'b0;
    chk("drain_exact4", bus.out_desc_valid, 1'b0);

    io_write(4'd1, 32'hFF000000, 4'b1000);
    io_write(4'd9, 32'h2, 4'hF);
    chk("merged_desc", bus.out_desc, 64'hFF000304_D0000004);
    bus.out_desc_ready = 1'b1;
    step();
    bus.out_desc_ready = 1'b0;

    bus.in_desc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_desc = {32'hB0000000 + i, 32'hA0000000 + i};
      step();
    end
    bus.in_desc = 64'hB0000005_A0000005;
    chk("full_not_ready", bus.in_desc_ready, 1'b0);
    io_write(4'd9, 32'h1, 4'hF);
    chk("pop_full_cnt3", bus.in_desc_ready, 1'b1);
    step();
    bus.in_desc_valid = 1'b0;
    chk("refill_cnt4", bus.in_desc_ready, 1'b0);
    io_read(4'd8, rd, rv);
    chk("status_in4", rd, 32'h00020004);
    io_read(4'd0, rd, rv);
    chk("head_a1", rd, 32'hA0000001);
    io_write(4'd9, 32'h1, 4'hF);
    io_read(4'd8, rd, rv);
    chk("status_in3", rd, 32'h00020003);
    bus.in_desc = 64'hB0000006_A0000006; bus.in_desc_valid = 1'b1;
    io_write(4'd9, 32'h1, 4'hF);
    bus.in_desc_valid = 1'b0;
    io_read(4'd8, rd, rv);
    chk("status_pop_enq", rd, 32'h00020003);
    io_read(4'd0, rd, rv);
    chk("head_a3", rd, 32'hA0000003);
    io_write(4'd9, 32'h1, 4'hF);
    io_read(4'd1, rd, rv);
    chk("head_b5", rd, 32'hB0000005);
    io_read(4'd0, rd, rv);
    chk("head_a5", rd, 32'hA0000005);
    io_write(4'd9, 32'h1, 4'hF);
    io_read(4'd0, rd, rv);
    chk("head_a6", rd, 32'hA0000006);
    io_write(4'd9, 32'h1, 4'hF);
    io_read(4'd8, rd, rv);
    chk("status_in0", rd, 32'h00020000);

    io_read(4'd0, rd, rv);
    chk("empty_rd_valid", rv, 1'b1);
    chk("empty_rd_data", rd, 32'h0);
    io_read(4'd8, rd, rv);
    chk("status_rd_empty", rd, 32'h00060000);
    chk("err_clear", bus.io_err, 1'b0);
    io_write(4'd8, 32'hFFFFFFFF, 4'hF);
    chk("err_wr_status", bus.io_err, 1'b1);
    io_read(4'd9, rd, rv);
    chk("ctrl_rd_zero", rd, 32'h0);
    bus.in_desc_valid = 1'b1;
    bus.in_desc = 64'h1; step();
    bus.in_desc = 64'h2; step();
    bus.in_desc_valid = 1'b0;
    io_write(4'd9, 32'h2, 4'hF);
    chk("pre_rst_out_valid", bus.out_desc_valid, 1'b1);
    rst = 1'b1;
    #2;
    chk("async_err", bus.io_err, 1'b0);
    chk("async_out_valid", bus.out_desc_valid, 1'b0);
    chk("async_in_ready", bus.in_desc_ready, 1'b1);
    step(); step();
    rst = 1'b0;
    step();
    io_read(4'd8, rd, rv);
    chk("post_rst_status", rd, 32'h0);
    io_read(4'd0, rd, rv);
    chk("post_rst_empty", rd, 32'h0);

    done = 1'b1;
    if (fails != 0) $error("FAIL summary: %0d of %0d checks failed", fails, tests);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/core_desc_io.md
CORE_DESC_IO -- requirements
Module: core_desc_io

Interface
REQ-001 SHALL have parameter DESC_WIDTH, default 64, descriptor width in bits; multiple of 32, 64..256.
REQ-002 SHALL have parameter IN_DEPTH, default 4, input descriptor FIFO entries; power of 2, >=2.
REQ-003 SHALL have parameter OUT_DEPTH, default 4, output descriptor FIFO entries; power of 2, >=2.
REQ-004 SHALL have parameter ADDR_WIDTH, default 16, core IO address width.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock.
REQ-007 core_reset  in  1  asynchronous, active-high reset.
REQ-008 io_v  in  1  core IO request strobe.
REQ-009 io_wr  in  1  1=write, 0=read.
REQ-010 io_addr  in  ADDR_WIDTH  byte address; bits [5:2] select the register.
REQ-011 io_wdata  in  32  write data.
REQ-012 io_wstrb  in  4  byte enables for writes.
REQ-013 io_rdata  out  32  read data.
REQ-014 io_rvalid  out  1  read data valid.
REQ-015 io_err  out  1  sticky access error.
REQ-016 in_desc  in  DESC_WIDTH  incoming descriptor.
REQ-017 in_desc_valid / in_desc_ready  in/out  1  incoming handshake.
REQ-018 out_desc  out  DESC_WIDTH  outgoing descriptor (output FIFO head).
REQ-019 out_desc_valid / out_desc_ready  out/in  1  outgoing handshake.

Function
REQ-020 Register map, W=DESC_WIDTH/32, word index k=io_addr[5:2]:
- k<W: read returns word k of the input FIFO head; write updates word k of the output staging register, byte-masked by io_wstrb.
- k=8 STATUS, read-only: [7:0]=in_count, [15:8]=out_count, [16]=in_ovf_free (constant 0), [17]=out_ovf, [18]=rd_empty.
- k=9 CTRL, write-only: bit0=POP input head, bit1=PUSH staging to the output FIFO.
REQ-021 Reads SHALL complete with io_rvalid=1 and io_rdata valid exactly 1 cycle after an io_v&!io_wr request.
REQ-022 A descriptor-word read while the input FIFO is empty SHALL return 0 and set the sticky rd_empty flag.
REQ-023 The input FIFO SHALL accept on in_desc_valid&in_desc_ready; in_desc_ready=(in_count<IN_DEPTH).
REQ-024 POP SHALL discard the head next cycle; POP while empty SHALL be ignored and set rd_empty.
REQ-025 PUSH SHALL copy staging, including any same-cycle byte writes, into the output FIFO.
REQ-026 PUSH while out_count==OUT_DEPTH SHALL drop the descriptor and set sticky out_ovf.
REQ-027 out_desc_valid=(out_count!=0); an entry leaves on out_desc_valid&out_desc_ready.
REQ-028 Simultaneous host enqueue and core POP on the input FIFO SHALL leave in_count unchanged; the same holds for PUSH and drain on the output FIFO.
REQ-029 Simultaneous POP and enqueue into a full input FIFO: in_desc_ready is 0, so the enqueue is refused that cycle.
REQ-030 Pointers SHALL wrap modulo depth; counts SHALL be clog2(depth)+1 bits, zero-extended into STATUS.
REQ-031 io_err SHALL set on:
- a write to STATUS or to k in W..7;
- a read of CTRL or of k in W..7;
- any k>9.
REQ-032 io_err, out_ovf and rd_empty SHALL clear only on reset.
REQ-033 The staging register SHALL persist after PUSH, so a partial rewrite then PUSH yields a merged descriptor.

Reset
REQ-034 On core_reset assertion, asynchronously:
- FIFO pointers and counts to 0;
- staging to 0;
- io_rvalid=0, io_rdata=0;
- io_err, out_ovf and rd_empty to 0;
- hence in_desc_ready=1, out_desc_valid=0.
REQ-035 Reset mid-transfer SHALL discard all queued descriptors; no handshake SHALL complete during reset.
REQ-036 Deassertion SHALL take effect at the next clk edge with all FIFOs empty.

Verification
REQ-037 Enqueue in_desc=0x11223344_55667788, read k=0 then k=1 -> io_rdata 0x55667788 then 0x11223344, each one cycle after request; POP -> STATUS[7:0]=0.
REQ-038 Write k=0 0xAABBCCDD, write k=1 0x01020304 with wstrb=0011, PUSH -> out_desc=0x00000304_AABBCCDD, out_desc_valid=1; out_desc_ready=1 -> out_count=0.
REQ-039 out_desc_ready=0, five PUSHes at OUT_DEPTH=4 -> out_count=4, out_ovf=1; draining yields exactly 4 descriptors, in push order.
REQ-040 Fill input FIFO (4 entries), then POP with in_desc_valid=1 in the same cycle -> in_count stays 3 that cycle then reaches 4; order preserved across pointer wrap.
REQ-041 Read k=0 on empty FIFO -> io_rdata=0, STATUS[18]=1; write STATUS -> io_err=1; assert core_reset with 2 entries queued -> in_count=0, io_err=0 immediately, without a clock edge.
